// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogrammed control sequencer with writable address map and control ROM
module micro_sequencer #(
  parameter int OPC_W = 4,
  parameter int CW_W = 12,
  parameter int UADDR_W = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
  input  logic               sysclk,
  input  logic               clear_n,
  input  logic               clken_oop,
  input  logic [OPC_W-1:0]   ir_opc,
  input  logic [1:0]         flags,
  input  logic               start,
  input  logic               prog_we,
  input  logic               prog_sel,
  input  logic [UADDR_W-1:0] prog_addr,
  input  logic [CW_W+2:0]    prog_data,
  output logic [CW_W-1:0]    cword,
  output logic               halt,
  output logic [UADDR_W-1:0] upc,
  output logic               running
);
  typedef enum logic [1:0] {PROG, RUN, HALT} state_t;
  localparam logic [1:0] SEQ_NEXT = 2'b00, SEQ_DISP = 2'b01, SEQ_END = 2'b10;
  state_t state, state_nxt;
  logic [CW_W+2:0] crom [2**UADDR_W];
  logic [UADDR_W-1:0] arom [2**OPC_W];
  logic [CW_W+2:0] mw;
  logic [1:0] seq;
  logic csel, halt_disp;
  logic [UADDR_W-1:0] upc_seq, upc_nxt;
  assign mw = crom[upc];
  assign seq = mw[CW_W+2:CW_W+1];
  assign csel = mw[CW_W];
  assign halt_disp = clken_oop && seq == SEQ_DISP && ir_opc == HALT_OPC;
  always_comb begin
    upc_seq = seq == SEQ_NEXT ? upc + UADDR_W'(1) :
              seq == SEQ_DISP ? arom[ir_opc] :
              seq == SEQ_END  ? '0 :
              upc + (flags[csel] ? UADDR_W'(2) : UADDR_W'(1));
  end
  always_ff @(posedge sysclk or negedge clear_n)
    if (!clear_n) begin
      state <= PROG;
      upc <= '0;
    end else begin
      state <= state_nxt;
      upc <= upc_nxt;
    end
  always_comb begin
    state_nxt = state == RUN ? (halt_disp ? HALT : RUN) : (start ? RUN : state);
    upc_nxt = state == RUN ? (clken_oop && !halt_disp ? upc_seq : upc) : (start ? '0 : upc);
  end
  always_comb begin
    cword = state == RUN ? mw[CW_W-1:0] : '0;
    halt = state == HALT;
    running = state == RUN;
  end
  always_ff @(posedge sysclk)
    if (state == PROG && prog_we) begin
      if (prog_sel) arom[prog_addr[OPC_W-1:0]] <= prog_data[UADDR_W-1:0];
      else crom[prog_addr] <= prog_data;
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed checks of fetch/dispatch, gating, skip, halt, write protection and reset
module tb_micro_sequencer;
  logic sysclk = 0, clear_n = 0, clken_oop = 0, start = 0, prog_we = 0, prog_sel = 0;
  logic [3:0] ir_opc = 0;
  logic [1:0] flags = 0;
  logic [4:0] prog_addr = 0;
  logic [14:0] prog_data = 0;
  logic [11:0] cword;
  logic halt, running;
  logic [4:0] upc;
  int checks = 0, errors = 0;
  micro_sequencer dut (
    .sysclk(sysclk), .clear_n(clear_n), .clken_oop(clken_oop), .ir_opc(ir_opc), .flags(flags),
    .start(start), .prog_we(prog_we), .prog_sel(prog_sel), .prog_addr(prog_addr),
    .prog_data(prog_data), .cword(cword), .halt(halt), .upc(upc), .running(running)
  );
  always #5 sysclk = ~sysclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [11:0] cw_e, input logic [4:0] upc_e, input logic ce);
    chk({tag, " cword"}, cword, cw_e);
    chk({tag, " upc"}, upc, upc_e);
    chk({tag, " running"}, running, 1);
    clken_oop = ce;
    @(negedge sysclk);
  endtask
  task automatic wr(input logic s, input logic [4:0] a, input logic [14:0] d);
    prog_sel = s;
    prog_addr = a;
    prog_data = d;
    prog_we = 1;
    @(negedge sysclk);
    prog_we = 0;
  endtask
  task automatic go;
    start = 1;
    @(negedge sysclk);
    start = 0;
  endtask
  task automatic sap_run(input string tag);
    cyc(tag, 12'hA00, 0, 1);
    cyc(tag, 12'h400, 1, 1);
    cyc(tag, 12'h0C0, 2, 1);
    cyc(tag, 12'h300, 4, 1);
    cyc(tag, 12'h050, 5, 1);
    cyc(tag, 12'hA00, 0, 1);
  endtask
  logic [11:0] g_cw [6] = '{12'hA00, 12'h400, 12'h0C0, 12'h300, 12'h050, 12'hA00};
  logic [4:0] g_upc [6] = '{0, 1, 2, 4, 5, 0};
  initial begin
    @(negedge sysclk);
    chk("rst cword", cword, 0);
    chk("rst halt", halt, 0);
    chk("rst running", running, 0);
    chk("rst upc", upc, 0);
    clear_n = 1;
    @(negedge sysclk);
    wr(0, 0, 15'h0A00);
    wr(0, 1, 15'h0400);
    wr(0, 2, 15'h20C0);
    wr(0, 4, 15'h0300);
    wr(0, 5, 15'h4050);
    wr(1, 0, 15'd4);
    chk("prog cword", cword, 0);
    clken_oop = 1;
    go();
    sap_run("sap");
    ir_opc = 4'hF;
    prog_sel = 0;
    prog_addr = 0;
    prog_data = 15'h0FFF;
    prog_we = 1;
    cyc("hlt", 12'h400, 1, 1);
    cyc("hlt", 12'h0C0, 2, 1);
    chk("hlt halt", halt, 1);
    chk("hlt cword", cword, 0);
    chk("hlt upc", upc, 2);
    chk("hlt running", running, 0);
    @(negedge sysclk);
    chk("hlt hold upc", upc, 2);
    chk("hlt hold halt", halt, 1);
    prog_we = 0;
    clken_oop = 0;
    ir_opc = 0;
    go();
    chk("restart halt", halt, 0);
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 3; k++)
        cyc("gate", g_cw[i], g_upc[i], k == 2);
    #2 clear_n = 0;
    #1;
    chk("arst cword", cword, 0);
    chk("arst running", running, 0);
    chk("arst halt", halt, 0);
    chk("arst upc", upc, 0);
    #1 clear_n = 1;
    @(negedge sysclk);
    clken_oop = 1;
    go();
    sap_run("replay");
    clear_n = 0;
    @(negedge sysclk);
    clear_n = 1;
    wr(0, 5, 15'h6055);
    wr(0, 6, 15'h4066);
    wr(0, 7, 15'h4077);
    wr(0, 31, 15'h70F1);
    wr(1, 2, 15'd31);
    flags = 2'b01;
    go();
    cyc("skip1", 12'hA00, 0, 1);
    cyc("skip1", 12'h400, 1, 1);
    cyc("skip1", 12'h0C0, 2, 1);
    cyc("skip1", 12'h300, 4, 1);
    cyc("skip1", 12'h055, 5, 1);
    cyc("skip1", 12'h077, 7, 1);
    cyc("skip1", 12'hA00, 0, 1);
    flags = 2'b10;
    cyc("skip0", 12'h400, 1, 1);
    cyc("skip0", 12'h0C0, 2, 1);
    cyc("skip0", 12'h300, 4, 1);
    cyc("skip0", 12'h055, 5, 1);
    cyc("skip0", 12'h066, 6, 1);
    cyc("skip0", 12'hA00, 0, 1);
    ir_opc = 2;
    cyc("wrap", 12'h400, 1, 1);
    cyc("wrap", 12'h0C0, 2, 1);
    cyc("wrap", 12'h0F1, 31, 1);
    cyc("wrap", 12'h400, 1, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogrammed control sequencer for the SAP CPU family. It succeeds the fixed 12-bit hardwired-ROM control unit with a sequencer that is generic in control-word width, opcode width and micro-address depth. Its address-map ROM and control ROM are writable at run time, and each microword carries explicit sequencing: next, dispatch, end, or skip-on-flag. It sits between the instruction register / ALU flags and every datapath enable.

## Interface
- OPC_W, 4: opcode width; the address map has 2^OPC_W entries.
- CW_W, 12: control-word width driven onto the datapath.
- UADDR_W, 5: micro-address width; the control ROM has 2^UADDR_W words.
- HALT_OPC, 4'hF: opcode that stops the sequencer. Its width is OPC_W.
- Constraint: CW_W+3 >= UADDR_W.

Ports:
- sysclk, in, 1: the single clock; all state updates on its rising edge.
- clear_n, in, 1: asynchronous, active-low reset.
- clken_oop, in, 1: micro-step advance enable, sampled at sysclk.
- ir_opc, in, OPC_W: current instruction opcode.
- flags, in, 2: ALU flags. Bit 0 is Z and bit 1 is C.
- start, in, 1: leaves PROG or HALT and begins execution at micro-address 0.
- prog_we, in, 1: microprogram write strobe.
- prog_sel, in, 1: write target. 0 selects the control ROM and 1 selects the address map.
- prog_addr, in, UADDR_W: write address.
- prog_data, in, CW_W+3: write data.
- cword, out, CW_W: active control word.
- halt, out, 1: high while in HALT.
- upc, out, UADDR_W: current micro-address, for debug.
- running, out, 1: high while in RUN.

## Operation
- Microword format: {seq[1:0], csel, cw[CW_W-1:0]}. It is stored in control ROM entry CROM[2^UADDR_W], each entry CW_W+3 bits wide.
- Sequencing field seq:
  - 00 NEXT: upc+1.
  - 01 DISPATCH: upc <= AROM[ir_opc].
  - 10 END: upc <= 0.
  - 11 SKIP: upc+2 if flags[csel]==1, else upc+1.
- All upc arithmetic is modulo 2^UADDR_W, so the last address wraps to 0.
- The address map is AROM[2^OPC_W], each entry UADDR_W bits wide.
- States: PROG, RUN, HALT. Reset puts the block in PROG.
- PROG:
  - cword=0.
  - A write happens on an edge with prog_we=1.
  - prog_sel=0: CROM[prog_addr] <= prog_data.
  - prog_sel=1: AROM[prog_addr[OPC_W-1:0]] <= prog_data[UADDR_W-1:0].
  - start=1 moves to RUN with upc=0. A write in the same cycle is still performed and is visible in RUN.
- RUN:
  - cword = CROM[upc].cw, combinationally.
  - On an edge with clken_oop=1, upc updates per seq. With clken_oop=0 all state holds.
  - If seq=DISPATCH and ir_opc==HALT_OPC at an advancing edge, the next state is HALT and upc holds.
  - prog_we is ignored and start is ignored.
- HALT:
  - cword=0 and halt=1.
  - start=1 moves to RUN with upc=0. clken_oop is not required for this transition.
  - prog_we is ignored.
- An all-zero cw does not implicitly restart the fetch. Only END restarts it.
- Memories are not reset. Their contents survive clear_n, and a bench must program them before start.

## Timing
- Reset values: state=PROG, upc=0, cword=0, halt=0, running=0.
- clear_n asserted mid-RUN forces the reset values immediately. Memory contents are kept.
- cword, halt and running decode state and upc combinationally. Each edge latency is therefore one edge after the enabling condition.
- DISPATCH samples ir_opc and applies the target at the same edge. The IR must be valid during the dispatch microword.
- SKIP samples flags at the advancing edge.
- start and the HALT_OPC dispatch cannot collide, because start is ignored in RUN.
- A write to the current CROM address in PROG has no effect on outputs, since cword=0 in PROG.

## Test plan
- SAP-1 image:
  - Load CROM 0..2 as fetch (0xA00 NEXT, 0x400 NEXT, 0x0C0 DISPATCH).
  - Load LDA at 4: 0x300 NEXT, 0x050 END.
  - Load AROM[0]=4.
  - Start with ir_opc=0 and clken_oop=1 every cycle.
  - Required cword sequence: 0xA00, 0x400, 0x0C0, 0x300, 0x050, then 0xA00.
- Gating: same image with clken_oop=1 only on every third cycle. Each cword is held for exactly 3 cycles and upc follows 0,1,2,4,5,0.
- SKIP:
  - Microword at 5 is SKIP with csel=0.
  - flags=2'b01 gives upc 5 to 7.
  - flags=2'b00 gives upc 5 to 6.
  - SKIP at the top address wraps: upc=31 with the flag set gives 1.
- HALT:
  - ir_opc=4'hF at DISPATCH produces halt=1 and cword=0 on the next edge, with upc held at 2.
  - start returns to RUN with upc=0 and halt=0.
- Write protection: prog_we in RUN writing CROM[0]=0xFFF. After HALT, then start, the first cword is still 0xA00.
- Async reset: drive clear_n low mid-RUN between edges. cword=0 and running=0 immediately. After release, with no reprogramming, start replays the original sequence.
